// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register result-latency countdown for decode hazards, plus drain handshake.
// Optional SB_STATS_EN adds the stat_stall_cycles counter output.
module hazard_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int LOAD_LAT = 1,
  parameter int ALU_LAT = 0,
  localparam int NREGS = 1 << ADDR_W,
  localparam int MAX_LAT = LOAD_LAT > ALU_LAT ? LOAD_LAT : ALU_LAT,
  localparam int CNT_W = MAX_LAT < 1 ? 1 : $clog2(MAX_LAT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic              id_re1,
  input  logic              id_re2,
  input  logic [ADDR_W-1:0] id_raddr1,
  input  logic [ADDR_W-1:0] id_raddr2,
  input  logic              id_we,
  input  logic [ADDR_W-1:0] id_waddr,
  input  logic              id_is_load,
  input  logic              drain_req,
  output logic              stallreq,
  output logic              issue,
  output logic [NREGS-1:0]  pending,
  output logic              drain_done
`ifdef SB_STATS_EN
  ,
  output logic [31:0]       stat_stall_cycles
`endif
);
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt [1:NREGS-1];
  logic [CNT_W-1:0] lat;
  logic hz1, hz2, all_zero;
  assign lat = id_is_load ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);
  assign hz1 = id_re1 && id_raddr1 != '0 && pending[id_raddr1];
  assign hz2 = id_re2 && id_raddr2 != '0 && pending[id_raddr2];
  assign stallreq = id_valid && (hz1 || hz2 || state != IDLE);
  assign issue = id_valid && !stallreq && !hold && !flush;
  assign all_zero = ~|pending;
  assign pending[0] = 1'b0;
  for (genvar g = 1; g < NREGS; g++) begin : g_reg
    logic [CNT_W-1:0] dec;
    assign dec = cnt[g] - CNT_W'(cnt[g] != '0);
    assign pending[g] = cnt[g] != '0;
    always_ff @(posedge clk or negedge rst)
      if (!rst) cnt[g] <= '0;
      else if (!hold) cnt[g] <= (issue && id_we && id_waddr == ADDR_W'(g)) ? (dec > lat ? dec : lat) : dec;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      drain_done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (drain_req) state <= DRAIN;
        DRAIN:
          if (!drain_req) state <= IDLE;
          else if (all_zero) begin
            state <= DONE;
            drain_done <= 1'b1;
          end
        DONE:
          if (!drain_req) begin
            state <= IDLE;
            drain_done <= 1'b0;
          end
        default: begin
          state <= IDLE;
          drain_done <= 1'b0;
        end
      endcase
    end
`ifdef SB_STATS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) stat_stall_cycles <= '0;
    else if (stallreq && !hold && !flush) stat_stall_cycles <= stat_stall_cycles + 32'd1;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks on three scoreboards (LOAD/ALU latency 1/0, 3/0, 2/1) sharing one stimulus.
module tb_hazard_scoreboard;
  logic clk = 0, rst = 0, hold = 0, flush = 0, drain_req = 0;
  logic id_valid = 0, id_re1 = 0, id_re2 = 0, id_we = 0, id_is_load = 0;
  logic [4:0] id_raddr1 = 0, id_raddr2 = 0, id_waddr = 0;
  logic st [3], is [3], dd [3];
  logic [31:0] pd [3];
`ifdef SB_STATS_EN
  logic [31:0] sc [3];
`endif
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  for (genvar k = 0; k < 3; k++) begin : g_dut
    hazard_scoreboard #(.LOAD_LAT(k == 0 ? 1 : k == 1 ? 3 : 2), .ALU_LAT(k == 2 ? 1 : 0)) u_dut (
      .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
      .id_re1(id_re1), .id_re2(id_re2), .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
      .id_we(id_we), .id_waddr(id_waddr), .id_is_load(id_is_load), .drain_req(drain_req),
      .stallreq(st[k]), .issue(is[k]), .pending(pd[k]), .drain_done(dd[k])
`ifdef SB_STATS_EN
      , .stat_stall_cycles(sc[k])
`endif
    );
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic ins(input logic v, input logic r1, input int a1, input logic r2, input int a2,
                     input logic w, input int wa, input logic ld);
    id_valid = v; id_re1 = r1; id_raddr1 = 5'(a1); id_re2 = r2; id_raddr2 = 5'(a2);
    id_we = w; id_waddr = 5'(wa); id_is_load = ld;
    #1;
  endtask
  task automatic do_reset;
    hold = 0; flush = 0; drain_req = 0; rst = 0;
    ins(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    rst = 1;
  endtask
  initial begin
    ins(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      check("rst_pending", pd[k], 0);
      check("rst_done", 32'(dd[k]), 0);
      check("rst_stall", 32'(st[k]), 0);
      check("rst_issue", 32'(is[k]), 0);
    end
`ifdef SB_STATS_EN
    check("rst_stat", sc[0], 0);
`endif
    tick; rst = 1;
    // load-use with defaults
    ins(1, 0, 0, 0, 0, 1, 5, 1);
    check("lu_lw_issue", 32'(is[0]), 1);
    tick;
    check("lu_pend5_on", 32'(pd[0][5]), 1);
    ins(1, 1, 5, 1, 1, 1, 6, 0);
    check("lu_stall", 32'(st[0]), 1);
    check("lu_noissue", 32'(is[0]), 0);
    tick;
    check("lu_pend5_off", 32'(pd[0][5]), 0);
    check("lu_nostall", 32'(st[0]), 0);
    check("lu_issue", 32'(is[0]), 1);
    tick;
    check("lu_alu_nopend", pd[0], 0);
    // LOAD_LAT=3 with hold pulsed two cycles mid-countdown
    do_reset;
    ins(1, 0, 0, 0, 0, 1, 5, 1);
    check("hold_lw_issue", 32'(is[1]), 1);
    tick;
    for (int i = 0; i < 5; i++) begin
      hold = (i == 1 || i == 2);
      ins(1, 1, 5, 0, 0, 1, 6, 0);
      check($sformatf("hold_stall%0d", i), 32'(st[1]), 1);
      check($sformatf("hold_noissue%0d", i), 32'(is[1]), 0);
      tick;
    end
    hold = 0;
    ins(1, 1, 5, 0, 0, 1, 6, 0);
    check("hold_issue", 32'(is[1]), 1);
    check("hold_pend_clear", pd[1], 0);
    // x0 never pending
    do_reset;
    ins(1, 0, 0, 0, 0, 1, 0, 1);
    check("x0_lw_issue", 32'(is[0]), 1);
    tick;
    check("x0_nopend", pd[0], 0);
    ins(1, 1, 0, 1, 0, 1, 1, 0);
    check("x0_nostall", 32'(st[0]), 0);
    check("x0_issue", 32'(is[0]), 1);
    tick;
    check("x0_nopend2", pd[0], 0);
    // WAW max rule
    do_reset;
    ins(1, 0, 0, 0, 0, 1, 7, 1);
    check("waw_lw_issue", 32'(is[2]), 1);
    tick;
    ins(1, 0, 0, 0, 0, 1, 7, 0);
    check("waw_addi_issue", 32'(is[2]), 1);
    check("waw_addi_issue3", 32'(is[1]), 1);
    tick;
    check("waw_pend", 32'(pd[2][7]), 1);
    ins(1, 1, 7, 0, 0, 0, 0, 0);
    check("waw_stall", 32'(st[2]), 1);
    check("waw_stall3", 32'(st[1]), 1);
    tick;
    check("waw_release", 32'(is[2]), 1);
    check("waw_keep_max3", 32'(st[1]), 1);
    tick;
    check("waw_release3", 32'(is[1]), 1);
    // flush with a hazard
    do_reset;
    ins(1, 0, 0, 0, 0, 1, 9, 1);
    check("fl_lw_issue", 32'(is[1]), 1);
    tick;
    flush = 1;
    ins(1, 1, 9, 0, 0, 1, 10, 0);
    check("fl_stall", 32'(st[1]), 1);
    check("fl_noissue", 32'(is[1]), 0);
    tick;
    flush = 0;
    ins(1, 1, 9, 0, 0, 1, 10, 0);
    check("fl_pend9", 32'(pd[1][9]), 1);
    check("fl_nopend10", 32'(pd[1][10]), 0);
    check("fl_stall2", 32'(st[1]), 1);
    tick;
    check("fl_stall3", 32'(st[1]), 1);
    tick;
    check("fl_issue", 32'(is[1]), 1);
    // drain with pending x3 (LOAD_LAT=2)
    do_reset;
    ins(1, 0, 0, 0, 0, 1, 3, 1);
    tick;
    drain_req = 1;
    ins(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    ins(1, 1, 1, 0, 0, 1, 4, 0);
    check("dr_pend3", 32'(pd[2][3]), 1);
    check("dr_stall", 32'(st[2]), 1);
    check("dr_noissue", 32'(is[2]), 0);
    check("dr_notdone", 32'(dd[2]), 0);
    tick;
    check("dr_pend3_off", 32'(pd[2][3]), 0);
    check("dr_notdone2", 32'(dd[2]), 0);
    tick;
    check("dr_done", 32'(dd[2]), 1);
    check("dr_done_noissue", 32'(is[2]), 0);
    tick;
    check("dr_done_hold", 32'(dd[2]), 1);
    drain_req = 0;
    ins(1, 1, 1, 0, 0, 1, 4, 0);
    check("dr_done_stall", 32'(st[2]), 1);
    tick;
    check("dr_idle_done", 32'(dd[2]), 0);
    check("dr_resume", 32'(is[2]), 1);
    // drain with nothing pending: one cycle in DRAIN
    do_reset;
    drain_req = 1;
    ins(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    check("dr0_draining", 32'(dd[0]), 0);
    tick;
    check("dr0_done", 32'(dd[0]), 1);
    // async reset mid-drain
    do_reset;
    ins(1, 0, 0, 0, 0, 1, 3, 1);
    tick;
    drain_req = 1;
    ins(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    drain_req = 0;
    rst = 0;
    ins(1, 1, 3, 0, 0, 0, 0, 0);
    check("ar_pend", pd[2], 0);
    check("ar_stall", 32'(st[2]), 0);
    rst = 1;
    tick;
    check("ar_pend2", pd[2], 0);
    check("ar_done", 32'(dd[2]), 0);
    check("ar_issue", 32'(is[2]), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
